rom_burst_reader: RTL and testbench
===================================

// Module: rom_burst_reader
// PURPOSE
//   Read-side controller for the 16x16 synchronous-address ROM. On START it fetches LEN
//   consecutive words from BASE, driving the ROM address/output-enable pins and capturing Q.
//   Captured words go into a DEPTH-entry FIFO and leave on a VALID/RDY stream.
//   A running sum of the delivered words is also kept.
//   Sits between the ROM macro and any consumer needing a block of coefficients.
// PARAMETERS
//   AW     4   ROM address width; burst addresses wrap modulo 2**AW
//   DW     16  ROM data width
//   DEPTH  4   FIFO entries, power of 2, >=2; DEPTH>=3 needed for 1 word/cycle
// PORTS
//   CK     in   1      clock, all state on posedge
//   RST_N  in   1      asynchronous active-low reset
//   START  in   1      request burst; sampled only when BUSY=0
//   BASE   in   AW     first ROM address, sampled with START
//   LEN    in   AW+1   word count 0..2**AW, sampled with START
//   ROM_A  out  AW     ROM address; ROM latches it every posedge
//   ROM_OE out  1      ROM output enable; ROM_Q is Z when low
//   ROM_Q  in   DW     ROM data, valid in the cycle after address latch while OE=1
//   DATA   out  DW     FIFO head word
//   VALID  out  1      DATA valid
//   RDY    in   1      consumer accepts DATA when VALID&RDY at posedge (pop)
//   BUSY   out  1      burst in progress
//   DONE   out  1      1-cycle pulse after last word is popped
//   SUM    out  DW+AW  mod-2**(DW+AW) sum of words popped in the current burst
// BEHAVIOUR
//   Reset (async, RST_N=0): state=IDLE, ROM_A=0, ROM_OE=0, VALID=0, DATA=0, BUSY=0, DONE=0, SUM=0.
//     FIFO pointers/count=0, in_flight=0, issue/pop counters=0.
//   Reset is honoured mid-burst: the burst is dropped, FIFO contents are lost, no DONE.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: START=1 at posedge -> latch BASE into addr and LEN into remaining; clear SUM and counters.
//     LEN=0 -> go to DONE; else go to RUN. BUSY=1 from the next cycle.
//   RUN issue rule: issue=(remaining_issue>0)&&(count+in_flight<DEPTH). No credit is taken
//     from a same-cycle pop.
//   ROM_A is a register holding the next address. On issue: at the posedge in_flight<=1,
//     addr<=addr+1 (AW-bit wrap, 4'hF->4'h0), remaining_issue-1. Otherwise in_flight<=0.
//   ROM_OE = in_flight (registered). The ROM drives Q only in capture cycles.
//   Capture: posedge with in_flight=1 pushes ROM_Q into the FIFO.
//   Pop: posedge with VALID&RDY; SUM<=SUM+DATA (zero-extend, wrap).
//   Push and pop in the same edge: count unchanged, both pointers advance.
//   Overflow is impossible by the credit rule; an assertion checks count<=DEPTH.
//   VALID=(count!=0); DATA=fifo[rd_ptr]. DATA must stay stable while VALID&!RDY.
//   Latency: START at edge n -> first ROM_A latched at edge n+1 -> captured at n+2 -> VALID from n+2.
//   With RDY=1 and DEPTH>=3, one word per cycle is sustained after the first.
//   RUN->DONE at the edge where the last of LEN words is popped (popped==LEN).
//   DONE state lasts exactly 1 cycle: DONE=1, BUSY=1, SUM final. Next edge -> IDLE, BUSY=0.
//   SUM holds its value until the next START.
//   START while BUSY=1 is ignored; BASE and LEN are not resampled.
//   START can be accepted in the IDLE cycle right after DONE.
//   RDY low stalls the pops. Issuing stops when the credit runs out; nothing is lost or duplicated.
// TESTING
//   T1 ROM[i]=16'h1000+i, BASE=2, LEN=5, RDY=1 -> DATA 1002..1006 in order.
//      First VALID 2 cycles after the START edge, back-to-back. DONE once, SUM=0x5014.
//   T2 BASE=14, LEN=4 -> addresses 14,15,0,1 (wrap); DATA=ROM[14],ROM[15],ROM[0],ROM[1].
//   T3 LEN=16, RDY toggling 1010... and randomised -> all 16 words exactly once, in order.
//      DATA stable while stalled; count never exceeds DEPTH; ROM_OE only high in capture cycles.
//   T4 LEN=0 -> DONE pulses 1 cycle after START, VALID never rises, SUM=0.
//      Second START mid-burst is ignored.
//   T5 RST_N low for 1 cycle mid-burst (after 3 of 8 words) -> all outputs at reset values
//      immediately. No DONE. A fresh START then runs correctly.

Source files
------------

// File: rtl/rom_burst_reader_if.sv
// Bundle of burst request, ROM pin and output stream signals for rom_burst_reader.
// The controller takes the slave side; the requester/ROM/consumer environment takes the master side.
interface rom_burst_reader_if #(
   parameter int AW = 4,
   parameter int DW = 16
);
   logic          START;
   logic [AW-1:0] BASE;
   logic [AW:0]   LEN;
   logic [AW-1:0] ROM_A;
   logic          ROM_OE;
   logic [DW-1:0] ROM_Q;
   logic [DW-1:0] DATA;
   logic          VALID;
   logic          RDY;
   logic          BUSY;
   logic          DONE;
   logic [DW+AW-1:0] SUM;

   modport slave (
      input  START, BASE, LEN, ROM_Q, RDY,
      output ROM_A, ROM_OE, DATA, VALID, BUSY, DONE, SUM
   );

   modport master (
      output START, BASE, LEN, ROM_Q, RDY,
      input  ROM_A, ROM_OE, DATA, VALID, BUSY, DONE, SUM
   );
endinterface

// File: rtl/rom_burst_reader.sv
// Burst reader for a synchronous-address ROM: fetches LEN words from BASE into a small
// credit-controlled FIFO, streams them out on VALID/RDY and sums the delivered words.
module rom_burst_reader #(
   parameter int AW    = 4,
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input logic                CK,
   input logic                RST_N,
   rom_burst_reader_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int LW = AW + 1;
   localparam int SW = DW + AW;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state;
   logic [AW-1:0] addr;
   logic [LW-1:0] rem_issue;
   logic [LW-1:0] len_q;
   logic [LW-1:0] popped;
   logic          in_flight;
   logic [DW-1:0] fifo [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [SW-1:0] sum;
   logic          busy;
   logic          done;

   logic issue;
   logic push;
   logic pop;
   logic valid;

   // NOTE: every signal is assigned on every pass through this block, so no latch can form.
   always_comb begin
      valid = (count != '0);
      push  = in_flight;
      pop   = valid && bus.RDY;
      // The word in flight already owns a FIFO slot; a same-cycle pop gives no extra credit.
      issue = (state == S_RUN) && (rem_issue != '0)
              && ((count + CW'(in_flight)) < CW'(DEPTH));
   end

   // NOTE: FIFO storage is left unreset; emptiness is tracked by count and DATA is gated by valid.
   always_ff @(posedge CK) begin
      if (push) fifo[wr_ptr] <= bus.ROM_Q;
   end

   // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         addr      <= '0;
         rem_issue <= '0;
         len_q     <= '0;
         popped    <= '0;
         in_flight <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         sum       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         if (issue) begin
            in_flight <= 1'b1;
            addr      <= addr + 1'b1;
            rem_issue <= rem_issue - 1'b1;
         end else begin
            in_flight <= 1'b0;
         end

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            sum    <= sum + SW'(bus.DATA);
            popped <= popped + 1'b1;
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            S_IDLE: begin
               if (bus.START) begin
                  addr      <= bus.BASE;
                  rem_issue <= bus.LEN;
                  len_q     <= bus.LEN;
                  popped    <= '0;
                  sum       <= '0;
                  busy      <= 1'b1;
                  if (bus.LEN == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (pop && ((popped + 1'b1) == len_q)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ROM_A  = addr;
   assign bus.ROM_OE = in_flight;
   assign bus.VALID  = valid;
   assign bus.DATA   = valid ? fifo[rd_ptr] : '0;
   assign bus.BUSY   = busy;
   assign bus.DONE   = done;
   assign bus.SUM    = sum;

   a_no_overflow: assert property (@(posedge CK) disable iff (!RST_N) count <= CW'(DEPTH));
endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: models the 16x16 ROM, records popped words and
// checks ordering, latency, wrap, stalls, LEN=0, ignored START and mid-burst reset.
module tb_rom_burst_reader;
   logic CK;
   logic RST_N;

   rom_burst_reader_if #(.AW(4), .DW(16)) bus ();

   rom_burst_reader #(.AW(4), .DW(16), .DEPTH(4)) dut (
      .CK    (CK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   logic [15:0] rom [16];
   logic [3:0]  rom_a_q;

   // ROM latches its address every edge; off-enable cycles return a marker instead of Z.
   always @(posedge CK) rom_a_q <= bus.ROM_A;
   assign bus.ROM_Q = bus.ROM_OE ? rom[rom_a_q] : 16'hDEAD;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] got [$];
   int          done_cnt = 0;
   int          oe_cnt = 0;
   int          stall_err = 0;
   int          max_cnt = 0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_data;

   always @(posedge CK) begin
      if (bus.VALID && bus.RDY) got.push_back(bus.DATA);
      if (bus.DONE) done_cnt <= done_cnt + 1;
      if (bus.ROM_OE) oe_cnt <= oe_cnt + 1;
      if (prev_stall && (bus.DATA !== prev_data)) stall_err <= stall_err + 1;
      prev_stall <= bus.VALID && !bus.RDY;
      prev_data  <= bus.DATA;
      if (int'(dut.count) > max_cnt) max_cnt <= int'(dut.count);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic start_burst(input logic [3:0] base, input logic [4:0] len);
      bus.START = 1'b1;
      bus.BASE  = base;
      bus.LEN   = len;
      tick();
      bus.START = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.DONE) break;
      end
      check({tag, "_done"}, 64'(bus.DONE), 64'd1);
   endtask

   int g0;
   int d0;
   int o0;

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
      RST_N     = 1'b0;
      bus.START = 1'b0;
      bus.BASE  = '0;
      bus.LEN   = '0;
      bus.RDY   = 1'b0;
      repeat (2) tick();

      check("rst_rom_a", 64'(bus.ROM_A), 64'd0);
      check("rst_rom_oe", 64'(bus.ROM_OE), 64'd0);
      check("rst_valid", 64'(bus.VALID), 64'd0);
      check("rst_data", 64'(bus.DATA), 64'd0);
      check("rst_busy", 64'(bus.BUSY), 64'd0);
      check("rst_done", 64'(bus.DONE), 64'd0);
      check("rst_sum", 64'(bus.SUM), 64'd0);
      RST_N = 1'b1;
      tick();

      // T1: BASE=2 LEN=5, RDY held high
      d0 = done_cnt;
      bus.RDY = 1'b1;
      start_burst(4'd2, 5'd5);
      check("t1_busy_n", 64'(bus.BUSY), 64'd1);
      check("t1_valid_n", 64'(bus.VALID), 64'd0);
      tick();
      check("t1_valid_n1", 64'(bus.VALID), 64'd0);
      check("t1_oe_n1", 64'(bus.ROM_OE), 64'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("t1_valid_w%0d", k), 64'(bus.VALID), 64'd1);
         check($sformatf("t1_data_w%0d", k), 64'(bus.DATA), 64'(16'h1002 + 16'(k)));
      end
      tick();
      check("t1_done", 64'(bus.DONE), 64'd1);
      check("t1_busy_done", 64'(bus.BUSY), 64'd1);
      check("t1_sum", 64'(bus.SUM), 64'h5014);
      check("t1_valid_end", 64'(bus.VALID), 64'd0);
      tick();
      check("t1_done_clr", 64'(bus.DONE), 64'd0);
      check("t1_busy_clr", 64'(bus.BUSY), 64'd0);
      check("t1_sum_hold", 64'(bus.SUM), 64'h5014);
      tick();
      check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

      // T2: address wrap 14,15,0,1
      g0 = got.size();
      start_burst(4'd14, 5'd4);
      wait_done("t2");
      check("t2_sum", 64'(bus.SUM), 64'h401E);
      tick();
      check("t2_count", 64'(got.size() - g0), 64'd4);
      check("t2_w0", 64'(got[g0 + 0]), 64'h100E);
      check("t2_w1", 64'(got[g0 + 1]), 64'h100F);
      check("t2_w2", 64'(got[g0 + 2]), 64'h1000);
      check("t2_w3", 64'(got[g0 + 3]), 64'h1001);

      // T3: full 16-word burst with toggling then random RDY
      g0 = got.size();
      d0 = done_cnt;
      o0 = oe_cnt;
      start_burst(4'd0, 5'd16);
      for (int i = 0; i < 400; i++) begin
         bus.RDY = (i < 16) ? ~i[0] : 1'($urandom_range(0, 1));
         tick();
         if (bus.DONE) break;
      end
      check("t3_done", 64'(bus.DONE), 64'd1);
      check("t3_sum", 64'(bus.SUM), 64'h10078);
      bus.RDY = 1'b1;
      tick();
      check("t3_count", 64'(got.size() - g0), 64'd16);
      for (int i = 0; i < 16; i++)
         if (g0 + i < got.size())
            check($sformatf("t3_w%0d", i), 64'(got[g0 + i]), 64'(16'h1000 + 16'(i)));
      check("t3_oe_cycles", 64'(oe_cnt - o0), 64'd16);
      check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
      check("t3_stall_stable", 64'(stall_err), 64'd0);
      check("t3_max_count_ok", 64'(max_cnt <= 4), 64'd1);

      // T4: LEN=0, then an ignored START during a stalled burst
      g0 = got.size();
      o0 = oe_cnt;
      start_burst(4'd5, 5'd0);
      check("t4_done", 64'(bus.DONE), 64'd1);
      check("t4_busy", 64'(bus.BUSY), 64'd1);
      check("t4_valid", 64'(bus.VALID), 64'd0);
      check("t4_sum", 64'(bus.SUM), 64'd0);
      tick();
      check("t4_done_clr", 64'(bus.DONE), 64'd0);
      check("t4_busy_clr", 64'(bus.BUSY), 64'd0);
      check("t4_no_words", 64'(got.size() - g0), 64'd0);
      check("t4_no_oe", 64'(oe_cnt - o0), 64'd0);

      bus.RDY = 1'b0;
      start_burst(4'd0, 5'd3);
      repeat (2) tick();
      start_burst(4'd8, 5'd5);
      check("t4_busy_mid", 64'(bus.BUSY), 64'd1);
      bus.RDY = 1'b1;
      wait_done("t4b");
      check("t4b_sum", 64'(bus.SUM), 64'h3003);
      tick();
      check("t4b_count", 64'(got.size() - g0), 64'd3);
      for (int i = 0; i < 3; i++)
         if (g0 + i < got.size())
            check($sformatf("t4b_w%0d", i), 64'(got[g0 + i]), 64'(16'h1000 + 16'(i)));
      check("t4b_oe_cycles", 64'(oe_cnt - o0), 64'd3);

      // T5: reset after 3 of 8 words, then a fresh burst
      g0 = got.size();
      d0 = done_cnt;
      start_burst(4'd0, 5'd8);
      for (int i = 0; i < 50; i++) begin
         tick();
         if (got.size() - g0 >= 3) break;
      end
      check("t5_three_popped", 64'(got.size() - g0), 64'd3);
      RST_N = 1'b0;
      #1;
      check("t5_rst_valid", 64'(bus.VALID), 64'd0);
      check("t5_rst_data", 64'(bus.DATA), 64'd0);
      check("t5_rst_busy", 64'(bus.BUSY), 64'd0);
      check("t5_rst_oe", 64'(bus.ROM_OE), 64'd0);
      check("t5_rst_rom_a", 64'(bus.ROM_A), 64'd0);
      check("t5_rst_sum", 64'(bus.SUM), 64'd0);
      check("t5_rst_done", 64'(bus.DONE), 64'd0);
      tick();
      RST_N = 1'b1;
      repeat (3) tick();
      check("t5_no_done", 64'(done_cnt - d0), 64'd0);
      check("t5_idle_valid", 64'(bus.VALID), 64'd0);

      g0 = got.size();
      start_burst(4'd4, 5'd3);
      wait_done("t5b");
      check("t5b_sum", 64'(bus.SUM), 64'h300F);
      tick();
      check("t5b_count", 64'(got.size() - g0), 64'd3);
      for (int i = 0; i < 3; i++)
         if (g0 + i < got.size())
            check($sformatf("t5b_w%0d", i), 64'(got[g0 + i]), 64'(16'h1004 + 16'(i)));
      check("t5b_done_cnt", 64'(done_cnt - d0), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
